// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences PC, instruction-memory read and MDR strobes,
// then hands each instruction to decode with a valid/ready handshake.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_rd, mem_addr           read request and its registered address
//   mem_ready                  memory data present on MDR input this cycle
//   MDR_wr, MDR_rd             MDR capture / output-load strobes
//   inst_valid, inst_ready     decode handshake
//   pc                         address of instruction in flight/presented
//   redirect, redirect_pc      branch/exception redirect and its target
//   fetch_cnt                  instructions accepted by decode (wrapping)
module fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  output logic              MDR_wr,
  output logic              MDR_rd,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    ISSUE,
    VALID
  } state_t;

  state_t state;
  logic kill;

  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic done;

  assign tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc = pc + ADDR_W'(4);
  assign done = (state == WAIT) && mem_ready;

  // A read that was overtaken by a redirect completes on the bus
  // but its data is never captured.
  assign MDR_wr = done && !kill && !redirect;
  assign MDR_rd = (state == ISSUE) && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_rd <= 1'b0;
      inst_valid <= 1'b0;
      kill <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= ADDR;
          mem_rd <= 1'b1;
          if (redirect) begin
            pc <= tgt;
            mem_addr <= tgt;
          end else begin
            mem_addr <= pc;
          end
        end
        ADDR: begin
          state <= WAIT;
          if (redirect) begin
            pc <= tgt;
            kill <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect) pc <= tgt;
          if (mem_ready) begin
            kill <= 1'b0;
            if (kill || redirect) begin
              // refetch straight away; mem_rd stays high
              state <= ADDR;
              mem_addr <= redirect ? tgt : pc;
            end else begin
              state <= ISSUE;
              mem_rd <= 1'b0;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        ISSUE: begin
          if (redirect) begin
            state <= ADDR;
            pc <= tgt;
            mem_addr <= tgt;
            mem_rd <= 1'b1;
          end else begin
            state <= VALID;
            inst_valid <= 1'b1;
          end
        end
        VALID: begin
          if (redirect) begin
            state <= ADDR;
            pc <= tgt;
            mem_addr <= tgt;
            mem_rd <= 1'b1;
            inst_valid <= 1'b0;
          end else if (inst_ready) begin
            state <= ADDR;
            pc <= pc_inc;
            mem_addr <= pc_inc;
            mem_rd <= 1'b1;
            inst_valid <= 1'b0;
            fetch_cnt <= fetch_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed stimulus for fetch_sequencer
// checked against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam int AW = 32;
  localparam int CW = 8;
  localparam logic [AW-1:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_rd;
  logic [AW-1:0] mem_addr;
  logic mem_ready = 1'b0;
  logic MDR_wr;
  logic MDR_rd;
  logic inst_valid;
  logic inst_ready = 1'b0;
  logic [AW-1:0] pc;
  logic redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [CW-1:0] fetch_cnt;

  fetch_sequencer #(
    .ADDR_W(AW),
    .RESET_PC(RPC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .MDR_wr(MDR_wr),
    .MDR_rd(MDR_rd),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .pc(pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model, in transaction terms: a read is either outstanding
  // or not, it may have been made stale by a redirect, completed data
  // is loaded one cycle later and then presented until accepted.
  bit armed = 1'b0;
  bit m_boot, m_rd, m_stale, m_load, m_valid;
  int m_age;
  logic [AW-1:0] m_pc, m_addr;
  logic [CW-1:0] m_cnt;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  task automatic begin_read;
    m_rd = 1'b1;
    m_age = 0;
    m_addr = m_pc;
    m_stale = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      m_boot = 1'b1;
      m_rd = 1'b0;
      m_stale = 1'b0;
      m_load = 1'b0;
      m_valid = 1'b0;
      m_age = 0;
      m_pc = RPC;
      m_addr = RPC;
      m_cnt = '0;
    end else if (armed) begin
      if (m_boot) begin
        m_boot = 1'b0;
        if (redirect) m_pc = align(redirect_pc);
        begin_read();
      end else if (m_rd) begin
        if (redirect) begin
          m_pc = align(redirect_pc);
          m_stale = 1'b1;
        end
        if (m_age >= 1 && mem_ready) begin
          if (m_stale) begin
            begin_read();
          end else begin
            m_rd = 1'b0;
            m_load = 1'b1;
          end
        end else begin
          m_age++;
        end
      end else if (m_load) begin
        m_load = 1'b0;
        if (redirect) begin
          m_pc = align(redirect_pc);
          begin_read();
        end else begin
          m_valid = 1'b1;
        end
      end else if (m_valid) begin
        if (redirect) begin
          m_valid = 1'b0;
          m_pc = align(redirect_pc);
          begin_read();
        end else if (inst_ready) begin
          m_valid = 1'b0;
          m_pc = m_pc + 32'd4;
          m_cnt = m_cnt + 1'b1;
          begin_read();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("mem_rd", 32'(mem_rd), 32'(m_rd));
      check("mem_addr", mem_addr, m_addr);
      check("MDR_wr", 32'(MDR_wr), 32'(m_rd && m_age >= 1 && mem_ready
                                      && !m_stale && !redirect));
      check("MDR_rd", 32'(MDR_rd), 32'(m_load && !redirect));
      check("overlap", 32'(MDR_wr & MDR_rd), 32'd0);
      check("inst_valid", 32'(inst_valid), 32'(m_valid));
      check("pc", pc, m_pc);
      check("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // w=0: read in its wait phase; w=1: instruction presented
  function automatic bit cond(input int w);
    return (w == 0) ? (m_rd && m_age >= 1) : m_valid;
  endfunction

  task automatic wait_for(input int w, input string tag);
    int n = 0;
    while (!cond(w) && n < 100) begin
      tick(1);
      n++;
    end
    if (!cond(w)) begin
      n_total++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles", tag, n);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, RPC);
    check({tag, "_MDR_rd"}, 32'(MDR_rd), 32'd0);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_pc"}, pc, RPC);
    check({tag, "_cnt"}, 32'(fetch_cnt), 32'd0);
  endtask

  logic [CW-1:0] c0;

  initial begin
    tick(3);
    check_reset("por");
    rst = 1'b0;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    tick(18);
    check("cnt_after_16", 32'(fetch_cnt), 32'd4);

    // slow memory, stalled decode
    mem_ready = 1'b0;
    inst_ready = 1'b0;
    tick(4);
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    tick(3);
    mem_ready = 1'b1;
    tick(8);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;

    // redirect while a read is outstanding
    mem_ready = 1'b0;
    wait_for(0, "wait_phase");
    c0 = m_cnt;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick(1);
    redirect = 1'b0;
    tick(2);
    mem_ready = 1'b1;
    tick(1);
    check("redir_wait_addr", mem_addr, 32'h0000_0100);
    check("redir_wait_rd", 32'(mem_rd), 32'd1);
    check("redir_wait_cnt", 32'(fetch_cnt), 32'(c0));

    // redirect racing an accept
    inst_ready = 1'b0;
    wait_for(1, "valid_phase");
    c0 = m_cnt;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    inst_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    inst_ready = 1'b0;
    check("redir_valid_addr", mem_addr, 32'h0000_0200);
    check("redir_valid_cnt", 32'(fetch_cnt), 32'(c0));
    check("redir_valid_drop", 32'(inst_valid), 32'd0);

    // reset with a read outstanding, then with an instruction presented
    mem_ready = 1'b0;
    wait_for(0, "rst_wait_phase");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("rst_wait");
    mem_ready = 1'b1;
    wait_for(1, "rst_valid_phase");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("rst_valid");
    tick(1);
    check("restart_addr", mem_addr, RPC);

    // pc wraps at the top of the address space
    wait_for(1, "wrap_valid1");
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    wait_for(1, "wrap_valid2");
    check("pc_top", pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick(1);
    check("pc_wrap", pc, 32'h0000_0000);

    // run the delivered counter through its wrap
    tick(4 * 260);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      mem_ready = ($urandom_range(0, 2) != 0);
      inst_ready = ($urandom_range(0, 1) != 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    redirect = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
